// File: rtl/opb_reg_pkg.sv
// Shared definitions for the PPC-to-Simulink OPB register bank.
package opb_reg_pkg;

  localparam int CNT_W    = 16;
  localparam int MAX_REGS = 16;

  // Status word returned at index C_NUM_REGS
  typedef struct packed {
    logic [31-CNT_W:0] rsvd;
    logic [CNT_W-1:0]  wr_count;
  } status_t;

  function automatic logic [31:0] status_word(input logic [CNT_W-1:0] count);
    status_t s;
    s.rsvd     = '0;
    s.wr_count = count;
    return s;
  endfunction

endpackage

// File: rtl/opb_reg_slice.sv
// One 32-bit user register with byte-lane writes and optional self-clear.
module opb_reg_slice
  import opb_reg_pkg::*;
#(
  parameter bit PULSE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  // Byte-lane update on write; trigger registers fall back to zero one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < 4; j++) begin
        if (be[j]) q[8*j +: 8] <= wdata[8*j +: 8];
      end
    end else if (PULSE) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS write registers to Simulink plus a write-count status word.
module opb_register_bank_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0]           C_BASEADDR   = 32'h0100E000,
  parameter logic [31:0]           C_HIGHADDR   = 32'h0100E0FF,
  parameter int                    C_NUM_REGS   = 4,
  parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK = '0,
  parameter int                    C_OPB_AWIDTH = 32,
  parameter int                    C_OPB_DWIDTH = 32
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]       OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]     OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]       OPB_DBus,
  input  logic                          OPB_RNW,
  input  logic                          OPB_select,
  input  logic                          OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]       Sl_DBus,
  output logic                          Sl_xferAck,
  output logic                          Sl_errAck,
  output logic                          Sl_retry,
  output logic                          Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]      user_data_out,
  output logic [C_NUM_REGS-1:0]         user_wr_strobe
);

  if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_bad_width
    $error("opb_register_bank_ppc2simulink: only 32-bit OPB buses are supported");
  end
  if (C_NUM_REGS < 1 || C_NUM_REGS > MAX_REGS) begin : g_bad_count
    $error("opb_register_bank_ppc2simulink: C_NUM_REGS out of range");
  end

  // Big-endian bus vectors land MSB-to-MSB in little-endian locals
  logic [31:0] addr, wdata, offset;
  logic [3:0]  be_lane;
  logic [29:0] word_idx;
  assign addr     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign be_lane  = OPB_BE;
  assign offset   = addr - C_BASEADDR;
  assign word_idx = offset[31:2];

  logic ack_p1;
  logic [31:0] rd_data_p1;
  logic [C_NUM_REGS-1:0] strobe_p1;
  logic [CNT_W-1:0] wr_count;

  logic in_win, hit, wr_hit, rd_hit, data_wr, stat_wr;
  // An ack cycle never starts a new transfer, so a held select acks every other cycle
  assign in_win  = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign hit     = OPB_select && in_win && !ack_p1;
  assign wr_hit  = hit && !OPB_RNW;
  assign rd_hit  = hit && OPB_RNW;
  assign data_wr = wr_hit && (word_idx < 30'(C_NUM_REGS));
  assign stat_wr = wr_hit && (word_idx == 30'(C_NUM_REGS));

  logic [C_NUM_REGS-1:0] reg_wr;
  logic [31:0] reg_q [C_NUM_REGS];

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg
    assign reg_wr[k] = data_wr && (word_idx == 30'(k));
    opb_reg_slice #(.PULSE(C_PULSE_MASK[k])) u_slice (
      .clk   (OPB_Clk),
      .rst_n (OPB_Rst_n),
      .wr_en (reg_wr[k]),
      .be    (be_lane),
      .wdata (wdata),
      .q     (reg_q[k])
    );
    assign user_data_out[32*k +: 32] = reg_q[k];
  end

  // Read mux: user registers, then the status word, zero for anything beyond
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (word_idx == 30'(k)) rd_word = reg_q[k];
    end
    if (word_idx == 30'(C_NUM_REGS)) rd_word = status_word(wr_count);
  end

  // Stage p1: acknowledge, read data and write strobes one cycle after the hit
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_p1     <= 1'b0;
      rd_data_p1 <= '0;
      strobe_p1  <= '0;
    end else begin
      ack_p1     <= hit;
      rd_data_p1 <= rd_hit ? rd_word : 32'h0;
      strobe_p1  <= reg_wr;
    end
  end

  // Write counter: counts user-register writes, cleared by a write to the status word
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      wr_count <= '0;
    end else if (stat_wr) begin
      wr_count <= '0;
    end else if (data_wr) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  assign Sl_xferAck     = ack_p1;
  assign Sl_DBus        = rd_data_p1;
  assign user_wr_strobe = strobe_p1;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

  logic unused;
  assign unused = ^{OPB_seqAddr, offset[1:0]};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the PPC-to-Simulink OPB register bank.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h0100E000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw, sel, seq_addr;
  logic [0:31] sl_dbus;
  logic        ack, err_ack, retry, tout_sup;
  logic [127:0] udo;
  logic [3:0]   strb;

  int checks = 0;
  int errors = 0;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (32'h0100E000),
    .C_HIGHADDR  (32'h0100E0FF),
    .C_NUM_REGS  (4),
    .C_PULSE_MASK(4'b0001)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst_n     (rst_n),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq_addr),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (ack),
    .Sl_errAck     (err_ack),
    .Sl_retry      (retry),
    .Sl_toutSup    (tout_sup),
    .user_data_out (udo),
    .user_wr_strobe(strb)
  );

  typedef struct {
    logic         rnw;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [31:0]  wd;
    logic         exp_ack;
    logic [31:0]  exp_rd;
    logic [3:0]   exp_st;
    logic [127:0] exp_u;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] u4(input logic [31:0] r3, input logic [31:0] r2,
                                      input logic [31:0] r1, input logic [31:0] r0);
    return {r3, r2, r1, r0};
  endfunction

  task automatic idle_bus();
    sel = 1'b0; rnw = 1'b1; abus = '0; be = '0; dbus = '0;
  endtask

  task automatic do_xfer(input logic r, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output logic ack_o, output logic [31:0] rd_o,
                         output logic [3:0] st_o, output logic [127:0] u_o);
    @(negedge clk);
    sel = 1'b1; rnw = r; abus = a; be = b; dbus = d;
    @(posedge clk); #1;
    ack_o = ack; rd_o = sl_dbus; st_o = strb; u_o = udo;
    @(negedge clk);
    idle_bus();
  endtask

  logic         a_o;
  logic [31:0]  rd_o;
  logic [3:0]   st_o;
  logic [127:0] u_o;

  initial begin
    seq_addr = 1'b0;
    idle_bus();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 128'(ack), 128'(0));
    chk("reset_dbus", 128'(sl_dbus), 128'(0));
    chk("reset_udo", udo, 128'(0));
    chk("reset_strobe", 128'(strb), 128'(0));
    chk("tied_outputs", 128'({err_ack, retry, tout_sup}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // rnw, addr, be, wdata, exp_ack, exp_rd, exp_strobe, exp_user
    vt.push_back('{1'b0, BASE+32'h04, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0, 4'b0010, u4(0, 0, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h04, 4'b0000, 32'h0, 1'b1, 32'hDEADBEEF, 4'b0000, u4(0, 0, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b0, BASE+32'h08, 4'b0100, 32'h11223344, 1'b1, 32'h0, 4'b0100, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h08, 4'b0000, 32'h0, 1'b1, 32'h00220000, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b0, BASE+32'h00, 4'b1111, 32'h00000001, 1'b1, 32'h0, 4'b0001, u4(0, 32'h00220000, 32'hDEADBEEF, 1)});
    vt.push_back('{1'b1, BASE+32'h00, 4'b0000, 32'h0, 1'b1, 32'h0, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h10, 4'b0000, 32'h0, 1'b1, 32'h3, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b0, BASE+32'h0C, 4'b0000, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b1000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h0C, 4'b0000, 32'h0, 1'b1, 32'h0, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h10, 4'b0000, 32'h0, 1'b1, 32'h4, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h24, 4'b0000, 32'h0, 1'b1, 32'h0, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b0, BASE+32'h24, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h10, 4'b0000, 32'h0, 1'b1, 32'h4, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b0, BASE+32'h10, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h10, 4'b0000, 32'h0, 1'b1, 32'h0, 4'b0000, u4(0, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b0, BASE+32'h0C, 4'b1001, 32'hA1B2C3D4, 1'b1, 32'h0, 4'b1000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h0C, 4'b0000, 32'h0, 1'b1, 32'hA10000D4, 4'b0000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h10, 4'b0000, 32'h0, 1'b1, 32'h1, 4'b0000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h100, 4'b0000, 32'h0, 1'b0, 32'h0, 4'b0000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE-32'h04, 4'b0000, 32'h0, 1'b0, 32'h0, 4'b0000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b0, BASE+32'hFC, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'hFC, 4'b0000, 32'h0, 1'b1, 32'h0, 4'b0000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b0, BASE+32'h100, 4'b1111, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b0000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});
    vt.push_back('{1'b1, BASE+32'h10, 4'b0000, 32'h0, 1'b1, 32'h1, 4'b0000, u4(32'hA10000D4, 32'h00220000, 32'hDEADBEEF, 0)});

    for (int i = 0; i < vt.size(); i++) begin
      do_xfer(vt[i].rnw, vt[i].addr, vt[i].be, vt[i].wd, a_o, rd_o, st_o, u_o);
      chk($sformatf("vec%0d_ack", i), 128'(a_o), 128'(vt[i].exp_ack));
      chk($sformatf("vec%0d_rdata", i), 128'(rd_o), 128'(vt[i].exp_rd));
      chk($sformatf("vec%0d_strobe", i), 128'(st_o), 128'(vt[i].exp_st));
      chk($sformatf("vec%0d_user", i), u_o, vt[i].exp_u);
    end

    // Pulse register 0: high for exactly one cycle after the write
    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = BASE; be = 4'b1111; dbus = 32'h00000001;
    @(posedge clk); #1;
    chk("pulse_n1_bit0", 128'(udo[0]), 128'(1));
    chk("pulse_n1_strobe", 128'(strb), 128'(4'b0001));
    @(negedge clk);
    idle_bus();
    @(posedge clk); #1;
    chk("pulse_n2_bit0", 128'(udo[0]), 128'(0));
    chk("pulse_n2_strobe", 128'(strb), 128'(0));

    // Select held for four cycles: acks only in cycles 2 and 4
    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = BASE + 32'h04; be = 4'b1111; dbus = 32'h5A5A5A5A;
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("held_c%0d_ack", c), 128'(ack), 128'((c % 2) == 0));
      chk($sformatf("held_c%0d_strobe", c), 128'(strb), 128'((c % 2) == 0 ? 4'b0010 : 4'b0000));
      if (c == 4) begin
        @(negedge clk);
        idle_bus();
      end
    end
    chk("held_user", udo[63:32], 128'(32'h5A5A5A5A));
    do_xfer(1'b1, BASE + 32'h10, 4'b0000, 32'h0, a_o, rd_o, st_o, u_o);
    chk("held_count", 128'(rd_o), 128'(32'h4));

    // Counter wrap: preload near the top, then three writes end on 0x0001
    @(negedge clk);
    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    for (int w = 0; w < 3; w++) do_xfer(1'b0, BASE + 32'h0C, 4'b0000, 32'h0, a_o, rd_o, st_o, u_o);
    do_xfer(1'b1, BASE + 32'h10, 4'b0000, 32'h0, a_o, rd_o, st_o, u_o);
    chk("wrap_status", 128'(rd_o), 128'(32'h00000001));
    do_xfer(1'b0, BASE + 32'h10, 4'b1111, 32'h0, a_o, rd_o, st_o, u_o);
    do_xfer(1'b1, BASE + 32'h10, 4'b0000, 32'h0, a_o, rd_o, st_o, u_o);
    chk("clear_status", 128'(rd_o), 128'(32'h0));

    // Reset lands on a write hit: transfer aborted, no ack afterwards
    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = BASE + 32'h08; be = 4'b1111; dbus = 32'h12345678;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_dbus", 128'(sl_dbus), 128'(0));
    chk("rst_udo", udo, 128'(0));
    chk("rst_strobe", 128'(strb), 128'(0));
    @(negedge clk);
    idle_bus();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_ack%0d", c), 128'(ack), 128'(0));
    end
    do_xfer(1'b1, BASE + 32'h08, 4'b0000, 32'h0, a_o, rd_o, st_o, u_o);
    chk("post_rst_reg2", 128'(rd_o), 128'(0));
    chk("post_rst_ack_read", 128'(a_o), 128'(1));
    do_xfer(1'b1, BASE + 32'h10, 4'b0000, 32'h0, a_o, rd_o, st_o, u_o);
    chk("post_rst_status", 128'(rd_o), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
